// File: rtl/bpu_pkg.sv
// bpu_pkg: 2-bit saturating counter type and state encodings for the branch predictor.
package bpu_pkg;
    typedef logic [1:0] ctr_t;
    localparam ctr_t ST_STRONG_T  = 2'b00;
    localparam ctr_t ST_WEAK_T    = 2'b01;
    localparam ctr_t ST_WEAK_NT   = 2'b10;
    localparam ctr_t ST_STRONG_NT = 2'b11;
    function automatic logic ctr_taken(input ctr_t c);
        return !c[1];
    endfunction
endpackage

// File: rtl/bpu_sat_counter.sv
// bpu_sat_counter: next-state of a 2-bit counter, stepping toward 00 on taken and 11 on not-taken.
module bpu_sat_counter
    import bpu_pkg::*;
(
    input  ctr_t state,
    input  logic taken,
    output ctr_t next
);
    always_comb begin
        next = taken ? ((state == ST_STRONG_T) ? state : state - 2'd1)
                     : ((state == ST_STRONG_NT) ? state : state + 2'd1);
    end
endmodule

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: 2-bit PHT predictor with EX-resolved updates, flush/redirect and statistics.
// Define BPU_BTB_EN to add a tag-less branch target buffer driving pred_target.
module branch_predictor_unit
    import bpu_pkg::*;
#(
    parameter int   INDEX_W    = 3,
    parameter int   PC_W       = 32,
    parameter ctr_t INIT_STATE = 2'b01,
    parameter int   STAT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_branch,
    input  logic [PC_W-1:0]   id_pc,
    input  logic              ex_branch,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_target,
    input  logic [PC_W-1:0]   ex_pc_plus4,
    output logic              predict_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);
    localparam int N = 1 << INDEX_W;
    ctr_t pht [N];
    logic [INDEX_W-1:0] id_idx, ex_idx;
    ctr_t ex_next, id_upd, id_ctr;
    logic same_idx, id_vld, mispred;
    logic unused_pc_bits;
    assign id_idx   = id_pc[INDEX_W+1:2];
    assign ex_idx   = ex_pc[INDEX_W+1:2];
    assign same_idx = ex_branch && (ex_idx == id_idx);
    assign unused_pc_bits = ^{id_pc[PC_W-1:INDEX_W+2], id_pc[1:0], ex_pc[PC_W-1:INDEX_W+2], ex_pc[1:0]};
    bpu_sat_counter u_upd (.state(pht[ex_idx]), .taken(ex_taken), .next(ex_next));
    bpu_sat_counter u_byp (.state(pht[id_idx]), .taken(ex_taken), .next(id_upd));
    assign id_ctr = same_idx ? id_upd : pht[id_idx];
    // judged against the carried prediction, not the current table contents
    assign mispred       = ex_branch && (ex_taken != ex_pred_taken);
    assign flush         = reset && mispred;
    assign redirect_pc   = reset ? (ex_taken ? ex_target : ex_pc_plus4) : '0;
    assign predict_taken = reset && id_branch && ctr_taken(id_ctr) && id_vld && !mispred;
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) pht[i] <= INIT_STATE;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (ex_branch) pht[ex_idx] <= ex_next;
            if (ex_branch && !(&branch_cnt)) branch_cnt <= branch_cnt + STAT_W'(1);
            if (mispred && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + STAT_W'(1);
        end
    end
`ifdef BPU_BTB_EN
    logic [PC_W-1:0] btb_tgt [N];
    logic [N-1:0]    btb_vld;
    logic            btb_wr, btb_byp;
    assign btb_wr      = ex_branch && ex_taken;
    assign btb_byp     = btb_wr && (ex_idx == id_idx);
    assign id_vld      = btb_byp || btb_vld[id_idx];
    assign pred_target = !reset ? '0 : (btb_byp ? ex_target : btb_tgt[id_idx]);
    always_ff @(posedge clk) begin
        if (!reset) btb_vld <= '0;
        else if (btb_wr) btb_vld[ex_idx] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset && btb_wr) btb_tgt[ex_idx] <= ex_target;
    end
`else
    assign id_vld      = 1'b1;
    assign pred_target = '0;
`endif
endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb_branch_predictor_unit: directed checks of prediction, bypass, flush, aliasing, BTB and counter saturation.
module tb_branch_predictor_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_branch, ex_branch, ex_taken, ex_pred_taken;
    logic [31:0] id_pc, ex_pc, ex_target, ex_pc_plus4;
    logic        predict_taken, flush;
    logic [31:0] pred_target, redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;
    int checks = 0;
    int errors = 0;

    branch_predictor_unit dut (
        .clk(clk), .reset(reset),
        .id_branch(id_branch), .id_pc(id_pc),
        .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4),
        .predict_taken(predict_taken), .pred_target(pred_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed time limit reached, required simulation end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ex_set(input logic br, input logic [31:0] pc, input logic tk, input logic pt);
        ex_branch = br; ex_pc = pc; ex_taken = tk; ex_pred_taken = pt;
        ex_target = pc + 32'h70; ex_pc_plus4 = pc + 32'd4;
        #1;
    endtask

    initial begin
        reset = 1'b0; id_branch = 1'b1; id_pc = 32'h10;
        ex_set(1'b1, 32'h10, 1'b0, 1'b1);
        tick();
        tick();
        check("rst_predict", {31'b0, predict_taken}, 32'd0);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_target", pred_target, 32'd0);
        check("rst_bcnt", {16'b0, branch_cnt}, 32'd0);
        reset = 1'b1;
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        check("init_predict", {31'b0, predict_taken}, 32'd1);
        check("init_bcnt", {16'b0, branch_cnt}, 32'd0);
        check("init_mcnt", {16'b0, mispred_cnt}, 32'd0);
        // four not-taken resolutions on 0x10 predicted taken: counter 01->10->11->11->11
        id_branch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex_set(1'b1, 32'h10, 1'b0, 1'b1);
            check("nt_flush", {31'b0, flush}, 32'd1);
            check("nt_redirect", redirect_pc, 32'h14);
            tick();
        end
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        check("nt_mcnt", {16'b0, mispred_cnt}, 32'd4);
        check("nt_bcnt", {16'b0, branch_cnt}, 32'd4);
        id_branch = 1'b1; id_pc = 32'h10; #1;
        check("nt_predict", {31'b0, predict_taken}, 32'd0);
        // one taken step from 11 lands on 10 (still not-taken), a second reaches 01
        id_branch = 1'b0;
        ex_set(1'b1, 32'h10, 1'b1, 1'b0);
        check("tk_flush", {31'b0, flush}, 32'd1);
        check("tk_redirect", redirect_pc, 32'h80);
        tick();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b1; #1;
        check("tk1_predict", {31'b0, predict_taken}, 32'd0);
        id_branch = 1'b0;
        ex_set(1'b1, 32'h10, 1'b1, 1'b1);
        check("tk2_flush", {31'b0, flush}, 32'd0);
        tick();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b1; #1;
        check("tk2_predict", {31'b0, predict_taken}, 32'd1);
        check("tk_mcnt", {16'b0, mispred_cnt}, 32'd5);
        check("tk_bcnt", {16'b0, branch_cnt}, 32'd6);
        // 0x24 to 10, then same-cycle taken update bypasses to ID
        id_branch = 1'b0;
        ex_set(1'b1, 32'h24, 1'b0, 1'b0);
        tick();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b1; id_pc = 32'h24; #1;
        check("byp_before", {31'b0, predict_taken}, 32'd0);
        ex_set(1'b1, 32'h24, 1'b1, 1'b1);
        check("byp_predict", {31'b0, predict_taken}, 32'd1);
        check("byp_flush", {31'b0, flush}, 32'd0);
        tick();
        // flush squashes a taken ID prediction
        ex_set(1'b1, 32'h10, 1'b0, 1'b1);
        check("squash_flush", {31'b0, flush}, 32'd1);
        check("squash_predict", {31'b0, predict_taken}, 32'd0);
        tick();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        check("squash_after", {31'b0, predict_taken}, 32'd1);
        // 0x20 and 0x0 share index 0
        id_branch = 1'b0;
        ex_set(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b1; id_pc = 32'h0; #1;
        check("alias_nt", {31'b0, predict_taken}, 32'd0);
        id_branch = 1'b0;
        ex_set(1'b1, 32'h0, 1'b1, 1'b1);
        tick();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b1; id_pc = 32'h20; #1;
        check("alias_tk", {31'b0, predict_taken}, 32'd1);
        check("alias_bcnt", {16'b0, branch_cnt}, 32'd11);
        check("alias_mcnt", {16'b0, mispred_cnt}, 32'd6);
        // taken branch at 0x40 with target 0x100
        id_branch = 1'b0;
        ex_set(1'b1, 32'h40, 1'b1, 1'b1);
        ex_target = 32'h100; #1;
        tick();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b1; id_pc = 32'h40; #1;
        check("btb_predict", {31'b0, predict_taken}, 32'd1);
`ifdef BPU_BTB_EN
        check("btb_target", pred_target, 32'h100);
`else
        check("btb_target", pred_target, 32'h0);
`endif
        // drive mispred_cnt from 6 up to saturation
        id_branch = 1'b0;
        ex_set(1'b1, 32'h8, 1'b0, 1'b1);
        for (int i = 0; i < 65528; i++) tick();
        check("sat_below", {16'b0, mispred_cnt}, 32'hFFFE);
        tick();
        check("sat_reach", {16'b0, mispred_cnt}, 32'hFFFF);
        tick();
        check("sat_hold", {16'b0, mispred_cnt}, 32'hFFFF);
        check("sat_bcnt", {16'b0, branch_cnt}, 32'hFFFF);
        // reset mid-operation with an EX update pending
        reset = 1'b0;
        ex_set(1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        ex_set(1'b0, 32'h0, 1'b0, 1'b0);
        id_branch = 1'b1; id_pc = 32'h10; #1;
        check("rst2_predict", {31'b0, predict_taken}, 32'd1);
        check("rst2_bcnt", {16'b0, branch_cnt}, 32'd0);
        check("rst2_mcnt", {16'b0, mispred_cnt}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
